// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, parity encodings and baud divisor helper for
//                the UART transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmit frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Parity selector encodings
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per line bit (integer division, remainder dropped)
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period divisor counter. Counts 0..DIV-1 and flags the
//                last cycle of every line bit; clear holds it at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic sclk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int                 c_cnt_w = $clog2(DIV);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  assign tick_o = (cnt_q == c_last);

  // Next count: wrap at end of bit, park at zero while cleared
  always_comb begin
    cnt_d = cnt_q + c_one;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Divisor register
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Configurable UART transmitter fed from a FIFO with one-cycle
//                read latency. Supports 5..9 data bits, none/odd/even parity
//                and 1 or 2 stop bits, with gapless back-to-back frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 RS232_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int         c_baud_div  = baud_div(CLK_HZ, BAUD);
  localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);
  localparam logic       c_par_odd   = (PARITY == PARITY_ODD);

  // Reject configurations the datapath cannot represent
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (c_baud_div < 4) begin : g_bad_baud_div
    $error("uart_tx_cfg: CLK_HZ/BAUD must be at least 4");
  end

  tx_state_e            state_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 ld_q;
  logic                 arm_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;

  logic baud_tick;
  logic baud_clr;
  logic last_stop;
  logic fetch;

  assign baud_clr  = (state_q == ST_IDLE);
  assign last_stop = (state_q == ST_STOP) && baud_tick && (bit_cnt_q == c_last_stop);
  // arm_q is cleared asynchronously, so no read strobe can escape during reset
  assign fetch     = arm_q && tx_en && !fifo_empty &&
                     ((state_q == ST_IDLE) || last_stop);

  assign fifo_rd_en = fetch;
  assign RS232_tx   = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  uart_baud_gen #(
    .DIV    (c_baud_div)
  ) u_baud_gen (
    .sclk   (sclk),
    .reset  (reset),
    .clr_i  (baud_clr),
    .tick_o (baud_tick)
  );

  // Frame sequencer; FIFO data arrives one cycle after the strobe, i.e.
  // during the first start-bit cycle, so it is latched there
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ld_q      <= 1'b0;
      arm_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      arm_q  <= 1'b1;
      done_q <= 1'b0;
      ld_q   <= fetch;
      if (ld_q) begin
        shift_q <= fifo_rd_data;
        par_q   <= (^fifo_rd_data) ^ c_par_odd;
      end
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (fetch) begin
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_cnt_q == c_last_data) begin
              bit_cnt_q <= '0;
              if (PARITY != PARITY_NONE) begin
                state_q <= ST_PAR;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        ST_PAR: begin
          if (baud_tick) begin
            state_q   <= ST_STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        ST_STOP: begin
          if (baud_tick) begin
            if (bit_cnt_q == c_last_stop) begin
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
              if (fetch) begin
                state_q <= ST_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Directed bench for uart_tx_cfg in 8N1, 7E2 and 8O1 builds,
//                each fed by a small FIFO model with one-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  localparam int BAUD_DIV = 434;
  localparam int HALF_PRE = BAUD_DIV / 2 - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] tx_en = 3'b000;
  logic [2:0] empty;
  logic [2:0] tx, busy, done, rd_en;
  logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2, rd0, rd1, rd2;
  logic [7:0] rdd0 = '0;
  logic [6:0] rdd1 = '0;
  logic [7:0] rdd2 = '0;

  assign tx    = {tx2, tx1, tx0};
  assign busy  = {busy2, busy1, busy0};
  assign done  = {done2, done1, done0};
  assign rd_en = {rd2, rd1, rd0};

  uart_tx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sclk(clk), .reset(rst_n), .tx_en(tx_en[0]), .fifo_empty(empty[0]),
    .fifo_rd_en(rd0), .fifo_rd_data(rdd0), .RS232_tx(tx0), .tx_busy(busy0), .tx_done(done0));
  uart_tx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .sclk(clk), .reset(rst_n), .tx_en(tx_en[1]), .fifo_empty(empty[1]),
    .fifo_rd_en(rd1), .fifo_rd_data(rdd1), .RS232_tx(tx1), .tx_busy(busy1), .tx_done(done1));
  uart_tx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .sclk(clk), .reset(rst_n), .tx_en(tx_en[2]), .fifo_empty(empty[2]),
    .fifo_rd_en(rd2), .fifo_rd_data(rdd2), .RS232_tx(tx2), .tx_busy(busy2), .tx_done(done2));

  // FIFO models: contents written by the stimulus, read pointer by the strobe
  logic [7:0] fmem [3][8];
  int fcnt [3] = '{0, 0, 0};
  int fptr [3] = '{0, 0, 0};

  always_comb begin
    for (int k = 0; k < 3; k++) empty[k] = (fptr[k] >= fcnt[k]);
  end

  always @(posedge clk) begin
    if (rd0) begin rdd0 <= fmem[0][fptr[0] % 8];      fptr[0] <= fptr[0] + 1; end
    if (rd1) begin rdd1 <= fmem[1][fptr[1] % 8][6:0]; fptr[1] <= fptr[1] + 1; end
    if (rd2) begin rdd2 <= fmem[2][fptr[2] % 8];      fptr[2] <= fptr[2] + 1; end
  end

  // Activity monitor
  int rd_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int low_cnt [3] = '{0, 0, 0};
  int run [3] = '{0, 0, 0};
  int last_run [3] = '{0, 0, 0};
  int bad_rd = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k]) rd_cnt[k]++;
      if (rd_en[k] && empty[k]) bad_rd++;
      if (done[k]) done_cnt[k]++;
      if (!tx[k]) low_cnt[k]++;
      if (busy[k]) run[k]++;
      else begin
        if (run[k] != 0) last_run[k] = run[k];
        run[k] = 0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] v);
    fmem[k][fcnt[k] % 8] = v;
    fcnt[k] = fcnt[k] + 1;
  endtask

  // Returns at the first falling-clock sample where the line is low
  task automatic wait_start(input int k, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (tx[k] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(tx[k]), 64'd0);
  endtask

  task automatic wait_idle(input int k, input string tag);
    int n;
    n = 0;
    while (busy[k] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(busy[k]), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Samples nbits line bits mid-bit, starting half a cycle into a start bit
  task automatic sample_line(input int k, input int nbits, output logic [63:0] bits);
    bits = '0;
    repeat (HALF_PRE) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (BAUD_DIV) @(negedge clk);
      bits[i] = tx[k];
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: cycle budget exhausted, n_errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits;
    int rd_base, done_base, low_base, n;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("reset_tx",    64'(tx),    64'b111);
    check_eq("reset_busy",  64'(busy),  64'b000);
    check_eq("reset_done",  64'(done),  64'b000);
    check_eq("reset_rd_en", 64'(rd_en), 64'b000);
    rst_n = 1'b1;
    tx_en = 3'b111;

    // Idle with empty FIFOs for 10000 cycles
    low_base = low_cnt[0] + low_cnt[1] + low_cnt[2];
    repeat (10000) @(negedge clk);
    check_eq("idle_rd_en", 64'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2]), 64'd0);
    check_eq("idle_tx_low", 64'(low_cnt[0] + low_cnt[1] + low_cnt[2] - low_base), 64'd0);

    // 8N1, 0x55
    rd_base = rd_cnt[0]; done_base = done_cnt[0];
    push(0, 8'h55);
    wait_start(0, "8n1_start");
    sample_line(0, 10, bits);
    check_eq("8n1_bits", bits, 64'b10_1010_1010);
    wait_idle(0, "8n1_idle");
    check_eq("8n1_len",  64'(last_run[0]), 64'd4340);
    check_eq("8n1_rd",   64'(rd_cnt[0] - rd_base), 64'd1);
    check_eq("8n1_done", 64'(done_cnt[0] - done_base), 64'd1);

    // 7E2, 0x41
    rd_base = rd_cnt[1]; done_base = done_cnt[1];
    @(negedge clk);
    push(1, 8'h41);
    wait_start(1, "7e2_start");
    sample_line(1, 11, bits);
    check_eq("7e2_bits", bits, 64'b110_1000_0010);
    wait_idle(1, "7e2_idle");
    check_eq("7e2_len",  64'(last_run[1]), 64'd4774);
    check_eq("7e2_rd",   64'(rd_cnt[1] - rd_base), 64'd1);
    check_eq("7e2_done", 64'(done_cnt[1] - done_base), 64'd1);

    // 8O1 back-to-back 0xA5, 0x00, 0xFF
    rd_base = rd_cnt[2]; done_base = done_cnt[2];
    @(negedge clk);
    push(2, 8'hA5); push(2, 8'h00); push(2, 8'hFF);
    wait_start(2, "8o1_start");
    sample_line(2, 33, bits);
    check_eq("8o1_bits", bits, 64'({11'b111_1111_1110, 11'b110_0000_0000, 11'b111_0100_1010}));
    wait_idle(2, "8o1_idle");
    check_eq("8o1_busy_len", 64'(last_run[2]), 64'd14322);
    check_eq("8o1_rd",       64'(rd_cnt[2] - rd_base), 64'd3);
    check_eq("8o1_done",     64'(done_cnt[2] - done_base), 64'd3);

    // Reset 2000 cycles into an 8N1 frame
    @(negedge clk);
    push(0, 8'hF0);
    wait_start(0, "rst_start");
    repeat (2000) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_tx",   64'(tx[0]),    64'd1);
    check_eq("rst_async_busy", 64'(busy[0]),  64'd0);
    check_eq("rst_async_done", 64'(done[0]),  64'd0);
    check_eq("rst_async_rd",   64'(rd_en[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_base = rd_cnt[0]; low_base = low_cnt[0];
    repeat (1000) @(negedge clk);
    check_eq("rst_after_tx_low", 64'(low_cnt[0] - low_base), 64'd0);
    check_eq("rst_after_rd",     64'(rd_cnt[0] - rd_base), 64'd0);

    // tx_en dropped mid-frame with a second byte queued
    rd_base = rd_cnt[0]; done_base = done_cnt[0];
    push(0, 8'h0F); push(0, 8'h3C);
    wait_start(0, "txen_start");
    repeat (1000) @(negedge clk);
    tx_en[0] = 1'b0;
    wait_idle(0, "txen_idle");
    check_eq("txen_rd_first",   64'(rd_cnt[0] - rd_base), 64'd1);
    check_eq("txen_done_first", 64'(done_cnt[0] - done_base), 64'd1);
    repeat (500) @(negedge clk);
    check_eq("txen_rd_hold", 64'(rd_cnt[0] - rd_base), 64'd1);
    check_eq("txen_tx_idle", 64'(tx[0]), 64'd1);
    tx_en[0] = 1'b1;
    n = 0;
    while (tx[0] !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("txen_restart_latency", 64'(n >= 1 && n <= 2), 64'd1);
    sample_line(0, 10, bits);
    check_eq("txen_bits", bits, 64'b10_0111_1000);
    wait_idle(0, "txen_idle2");
    check_eq("txen_rd_total",   64'(rd_cnt[0] - rd_base), 64'd2);
    check_eq("txen_done_total", 64'(done_cnt[0] - done_base), 64'd2);

    check_eq("rd_while_empty", 64'(bad_rd), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
